// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 2**SEL_W:1 mux: steps sel over every channel,
// waits SETTLE cycles per channel, rebuilds the word and reports ones count / first hit.
module mux_scan_ctrl #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  mux_f,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [2**SEL_W-1:0]   captured,
    output logic [SEL_W:0]        ones_count,
    output logic [SEL_W-1:0]      first_hit,
    output logic                  hit_valid,
    output logic [1:0]            dbg_state
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no settle time every channel goes straight to its sample cycle.
    localparam state_t ST_AFTER_SEL = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               busy_q;
    logic               done_q;
    logic [N-1:0]       captured_q;
    logic [SEL_W:0]     ones_q;
    logic [SEL_W-1:0]   first_q;
    logic               hit_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            captured_q <= '0;
            ones_q     <= '0;
            first_q    <= '0;
            hit_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_q      <= '0;
                        busy_q     <= 1'b1;
                        captured_q <= '0;
                        ones_q     <= '0;
                        first_q    <= '0;
                        hit_q      <= 1'b0;
                        cnt_q      <= RELOAD;
                        state_q    <= ST_AFTER_SEL;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    captured_q[sel_q] <= mux_f;
                    ones_q            <= ones_q + {{SEL_W{1'b0}}, mux_f};
                    if (mux_f && !hit_q) begin
                        first_q <= sel_q;
                        hit_q   <= 1'b1;
                    end
                    if (sel_q != SEL_MAX) begin
                        sel_q   <= sel_q + SEL_W'(1);
                        cnt_q   <= RELOAD;
                        state_q <= ST_AFTER_SEL;
                    end else begin
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign captured   = captured_q;
    assign ones_count = ones_q;
    assign first_hit  = first_q;
    assign hit_valid  = hit_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequential scan controller that drives the select lines of a 16:1 multiplexer and consumes the mux's single-bit output.
- On start, it steps sel through 0..15 and waits a programmable settle time per channel.
- It then samples the mux output and rebuilds the 16-bit word seen through the mux.
- It also reports the ones count and the index of the lowest-numbered set channel, then pulses done.
- It sits directly upstream (sel) and downstream (mux_f) of the 16:1 mux.

Parameters:
SEL_W, 4, select width; channel count N = 2**SEL_W (16 at default)
SETTLE, 1, wait cycles between driving a new sel value and sampling mux_f (0 allowed)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  synchronous active-low reset
start  input  1  request a scan; accepted only in IDLE
mux_f  input  1  output of the external 16:1 mux
sel  output  SEL_W  select driven to the mux
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a scan completes
captured  output  N  captured[i] = mux_f sampled while sel==i
ones_count  output  SEL_W+1  number of 1s in captured (0..16)
first_hit  output  SEL_W  lowest i with captured[i]==1; 0 if none
hit_valid  output  1  1 if any captured bit is 1

Behaviour:
Reset and sampling:
- One clock. Reset is synchronous and active-low: rstn is sampled on the rising edge of clk.
- When rstn==0 at an edge: state=IDLE, sel=0, busy=0, done=0, captured=0, ones_count=0, first_hit=0, hit_valid=0, settle counter=0.

States: IDLE, SETTLE, SAMPLE, DONE.

IDLE:
- If start==1 at an edge, the scan begins. At that edge: sel=0, busy=1, captured/ones_count/first_hit/hit_valid cleared to 0.
- Next state is SETTLE with counter=SETTLE-1, or SAMPLE if SETTLE==0.

SETTLE:
- Counter decrements each edge. When counter==0 at an edge, go to SAMPLE.
- sel is held stable throughout.

SAMPLE (one cycle per channel):
- At the edge: captured[sel] <= mux_f; ones_count += mux_f.
- If mux_f==1 and hit_valid==0: first_hit <= sel and hit_valid <= 1.
- If sel != N-1: sel increments and the next state is SETTLE (counter reloaded) or SAMPLE if SETTLE==0.
- If sel == N-1: the next state is DONE, sel returns to 0, busy <= 0, done <= 1.

DONE:
- Lasts one cycle. At the next edge: done <= 0, state=IDLE.

Timing:
- Each channel takes SETTLE+1 cycles.
- If start is accepted at edge 0, the last sample occurs at edge N*(SETTLE+1), and done is high during the following cycle (edge 32 for the defaults).
- Results are valid from the done cycle and held stable until the next accepted start.

Boundary conditions:
- start while busy or in DONE: ignored, with no effect on sel or results.
- start held high continuously: a new scan starts on the first IDLE edge after DONE.
- mux_f is sampled only in SAMPLE; its value in SETTLE or IDLE has no effect.
- Reset mid-scan: abort immediately to reset values; no done pulse.
- ones_count reaches 16 without overflow, which is why its width is SEL_W+1.
- sel never exceeds N-1 and wraps to 0 only on completion.

Test Plan:
For all scenarios, the bench models the mux as mux_f = pattern[sel], combinationally.
1. SETTLE=1, pattern 16'h0004, start pulsed -> done at edge 32; captured=16'h0004, ones_count=1, first_hit=2, hit_valid=1; busy high for edges 1..32.
2. Pattern 16'h2000, then a second scan with pattern 16'h0000 -> first scan: first_hit=13, ones_count=1; second scan: captured=0, ones_count=0, first_hit=0, hit_valid=0, with results cleared at the start edge.
3. Pattern 16'hFFFF -> ones_count=16, first_hit=0, captured=16'hFFFF; during SETTLE cycles, sel observed stepping 0..15, each value held 2 cycles.
4. start re-pulsed at edges 5 and 20 during a scan -> ignored; exactly one done pulse at edge 32.
5. rstn=0 at edge 10 mid-scan -> sel=0, busy=0, captured=0, no done; a new start then runs a clean full scan.
6. SETTLE=0 build, pattern 16'h8001 -> done at edge 16; ones_count=2, first_hit=0; sel changes every cycle.
